// File: rtl/psum_accum.sv
// Partial-sum accumulator: gathers NUM_PARTIALS signed partials per slot and emits results in slot order.
// Build option: define PSUM_SAT_EN to clamp results to OUT_W range; otherwise results wrap to the low OUT_W bits.
module psum_accum #(
    parameter int NUM_SLOTS    = 9,
    parameter int NUM_PARTIALS = 5,
    parameter int PSUM_W       = 8,
    parameter int OUT_W        = 8,
    parameter int ADDR_W       = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [ADDR_W-1:0]                             node_addr,
    input  logic [ADDR_W-1:0]                             mem_addr,
    input  logic                                          start,
    output logic                                          done,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [$clog2(NUM_SLOTS)-1:0]                  in_slot,
    input  logic [PSUM_W-1:0]                             in_psum,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [2*ADDR_W+$clog2(NUM_SLOTS)+OUT_W-1:0]   out_flit,
    output logic                                          err
);
    // state  | meaning
    // S_IDLE | waiting for start; in_ready low
    // S_RUN  | accepting partials and emitting slot results in order
    // S_DONE | all slots handed off; done high for this single cycle

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int PTR_W  = $clog2(NUM_SLOTS + 1);
    localparam int CNT_W  = $clog2(NUM_PARTIALS + 1);
    localparam int ACC_W  = PSUM_W + $clog2(NUM_PARTIALS) + 1;
    localparam int FLIT_W = 2*ADDR_W + SLOT_W + OUT_W;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NUM_PARTIALS);
    localparam logic [PTR_W-1:0]  PTR_END  = PTR_W'(NUM_SLOTS);
    localparam logic [SLOT_W:0]   SLOT_LIM = (SLOT_W+1)'(NUM_SLOTS);
`ifdef PSUM_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2**(OUT_W-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2**(OUT_W-1)));
`endif

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic signed [ACC_W-1:0]  r_acc [NUM_SLOTS];
    logic [CNT_W-1:0]         r_cnt [NUM_SLOTS];
    logic [PTR_W-1:0]         r_ptr;
    logic [ADDR_W-1:0]        r_node;
    logic [ADDR_W-1:0]        r_mem;
    logic                     r_out_valid;
    logic [FLIT_W-1:0]        r_flit;
    logic                     r_err;

    logic                     w_in_ready;
    logic                     w_done;
    logic                     w_start;
    logic                     w_accept;
    logic                     w_bad_slot;
    logic                     w_slot_full;
    logic                     w_ptr_live;
    logic                     w_ptr_full;
    logic                     w_hs;
    logic                     w_load;
    logic [SLOT_W-1:0]        w_ptr_idx;
    logic signed [ACC_W-1:0]  w_acc_ptr;
    logic signed [ACC_W-1:0]  w_psum_ext;
    logic [OUT_W-1:0]         w_result;

    assign w_start     = start && (r_state == S_IDLE);
    assign w_accept    = in_valid && w_in_ready;
    assign w_bad_slot  = ({1'b0, in_slot} >= SLOT_LIM);
    assign w_slot_full = (r_cnt[in_slot] == CNT_FULL);
    assign w_psum_ext  = {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
    assign w_ptr_idx   = r_ptr[SLOT_W-1:0];
    assign w_ptr_live  = (r_ptr < PTR_END);
    assign w_ptr_full  = w_ptr_live && (r_cnt[w_ptr_idx] == CNT_FULL);
    assign w_acc_ptr   = r_acc[w_ptr_idx];
    assign w_hs        = r_out_valid && out_ready;
    // A new flit may load into an empty output register or one being drained this edge.
    assign w_load      = (r_state == S_RUN) && w_ptr_full && (!r_out_valid || out_ready);

    always_comb begin
        w_result = OUT_W'(w_acc_ptr);
`ifdef PSUM_SAT_EN
        if (w_acc_ptr > SAT_HI) begin
            w_result = SAT_HI[OUT_W-1:0];
        end else if (w_acc_ptr < SAT_LO) begin
            w_result = SAT_LO[OUT_W-1:0];
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_in_ready = 1'b1;
                // Pointer at the end means the pending flit is the last slot.
                if (w_hs && (r_ptr == PTR_END)) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_acc[i] <= '0;
                r_cnt[i] <= '0;
            end
            r_ptr       <= '0;
            r_node      <= '0;
            r_mem       <= '0;
            r_out_valid <= 1'b0;
            r_flit      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_start) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_acc[i] <= '0;
                    r_cnt[i] <= '0;
                end
                r_ptr  <= '0;
                r_err  <= 1'b0;
                r_node <= node_addr;
                r_mem  <= mem_addr;
            end else if (r_state == S_RUN) begin
                if (w_accept) begin
                    if (w_bad_slot || w_slot_full) begin
                        r_err <= 1'b1;
                    end else begin
                        r_acc[in_slot] <= r_acc[in_slot] + w_psum_ext;
                        r_cnt[in_slot] <= r_cnt[in_slot] + CNT_W'(1);
                    end
                end
                if (w_load) begin
                    r_flit <= {r_mem, r_node, w_ptr_idx, w_result};
                    r_ptr  <= r_ptr + PTR_W'(1);
                end
            end

            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign done      = w_done;
    assign out_valid = r_out_valid;
    assign out_flit  = r_flit;
    assign err       = r_err;

endmodule

// File: tb/tb_psum_accum.sv
// Scoreboard bench for psum_accum (4 slots, 3 partials, 8-bit psum/result, 4-bit addresses).
module tb_psum_accum;
    localparam int NS = 4;
    localparam int NP = 3;
    localparam int AW = 4;
    localparam int OW = 8;
    localparam int FW = 2*AW + 2 + OW;
    localparam logic [AW-1:0] NODE = 4'h5;
    localparam logic [AW-1:0] MEM  = 4'hA;

    logic          clk;
    logic          reset;
    logic [AW-1:0] node_addr;
    logic [AW-1:0] mem_addr;
    logic          start;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_slot;
    logic [7:0]    in_psum;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_flit;
    logic          err;

    int n_cmp = 0;
    int n_bad = 0;
    logic [FW-1:0] sb_q[$];
    int m_acc[NS];
    int m_cnt[NS];
    int push_ptr;

    psum_accum #(.NUM_SLOTS(NS), .NUM_PARTIALS(NP), .PSUM_W(8), .OUT_W(OW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .node_addr(node_addr), .mem_addr(mem_addr),
        .start(start), .done(done), .in_valid(in_valid), .in_ready(in_ready),
        .in_slot(in_slot), .in_psum(in_psum), .out_valid(out_valid),
        .out_ready(out_ready), .out_flit(out_flit), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int conv(input int a);
`ifdef PSUM_SAT_EN
        if (a > 127) return 127;
        if (a < -128) return -128;
        return a;
`else
        return a & 255;
`endif
    endfunction

    function automatic logic [FW-1:0] mk(input int slot, input int res);
        logic [1:0] s;
        logic [7:0] r;
        s = slot[1:0];
        r = res[7:0];
        return {MEM, NODE, s, r};
    endfunction

    // Output monitor: every handshake pops the next expected flit.
    always @(negedge clk) begin : mon
        logic [FW-1:0] e;
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_bad++;
                $display("FAIL flit_unexpected: got %h, required none pending", out_flit);
            end else begin
                e = sb_q.pop_front();
                if (out_flit !== e) begin
                    n_bad++;
                    $display("FAIL flit: got %h, required %h", out_flit, e);
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NS; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
        push_ptr = 0;
    endtask

    task automatic send(input int slot, input int v);
        in_valid = 1'b1;
        in_slot  = 2'(slot);
        in_psum  = 8'(v);
        if (m_cnt[slot] < NP) begin
            m_acc[slot] += v;
            m_cnt[slot]++;
        end
        while (push_ptr < NS && m_cnt[push_ptr] == NP) begin
            sb_q.push_back(mk(push_ptr, conv(m_acc[push_ptr])));
            push_ptr++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic start_job();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL start_in_ready: got %b, required 1", in_ready);
        end
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_done_timeout: got no done in 60 cycles, required done pulse", name);
        end else begin
            n_cmp++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL %s_flits_left: got %0d pending, required 0", name, sb_q.size());
            end
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_done_width: got %b, required 0", name, done);
            end
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s_idle: in_ready got %b, required 0", name, in_ready);
            end
        end
        sb_q.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({out_valid, in_ready, done, err} !== 4'b0000 || out_flit !== '0) begin
            n_bad++;
            $display("FAIL %s: got v/r/d/e=%b%b%b%b flit=%h, required 0000 flit=0",
                     name, out_valid, in_ready, done, err, out_flit);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #12;
        check_zero("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        start_job();
        send(0, 1);
        send(0, 1);
        #2;
        reset = 1'b1;
        #1;
        check_zero("reset_mid_run");
        sb_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        start_job();
        for (int k = 0; k < NP; k++) send(0, 1);
        for (int s = 1; s < NS; s++)
            for (int k = 0; k < NP; k++) send(s, 0);
        wait_done("reset");
    endtask

    task automatic test_basic();
        int vals[9] = '{-5, 7, 2, 127, 127, 127, -128, -128, -128};
        start_job();
        send(0, 1);
        send(0, 2);
        send(0, 3);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL latency_early: out_valid got %b, required 0", out_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_flit !== mk(0, 6)) begin
            n_bad++;
            $display("FAIL latency_flit: got v=%b flit=%h, required v=1 flit=%h", out_valid, out_flit, mk(0, 6));
        end
        for (int s = 1; s < NS; s++)
            for (int k = 0; k < NP; k++) send(s, vals[(s-1)*NP + k]);
        wait_done("basic");
    endtask

    task automatic test_order();
        start_job();
        node_addr = 4'h0;
        mem_addr  = 4'hF;
        for (int k = 0; k < NP; k++) send(1, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL order_hold: out_valid got %b, required 0", out_valid);
            end
        end
        @(posedge clk); #1;
        for (int k = 0; k < NP; k++) send(0, -1);
        send(2, 10);
        send(2, -20);
        send(2, 5);
        for (int k = 0; k < NP; k++) send(3, 0);
        wait_done("order");
        node_addr = NODE;
        mem_addr  = MEM;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_job();
        for (int k = 0; k < NP; k++) send(0, -7);
        for (int i = 0; i < 5; i++) begin
            send((i < 3) ? 1 : 2, 20 + i);
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_flit !== mk(0, conv(-21))) begin
                n_bad++;
                $display("FAIL bp_hold: got v=%b r=%b flit=%h, required v=1 r=1 flit=%h",
                         out_valid, in_ready, out_flit, mk(0, conv(-21)));
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(2, 1);
        for (int k = 0; k < NP; k++) send(3, 9);
        wait_done("backpressure");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        start_job();
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NP; k++) send(s, s*10 - k);
        @(posedge clk); #1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b_gap: cycle %0d out_valid got %b, required 1", i, out_valid);
            end
        end
        wait_done("back_to_back");
    endtask

    task automatic test_sat();
        start_job();
        for (int k = 0; k < NP; k++) send(2, 100);
        for (int k = 0; k < NP; k++) send(0, 50);
        for (int k = 0; k < NP; k++) send(1, -100);
        send(3, 1);
        send(3, 2);
        send(3, 3);
        wait_done("sat");
    endtask

    task automatic test_err();
        start_job();
        send(0, 1);
        send(0, 2);
        send(0, 3);
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clean: got %b, required 0", err);
        end
        send(0, 99);
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_set: got %b, required 1", err);
        end
        for (int s = 1; s < NS; s++)
            for (int k = 0; k < NP; k++) send(s, -s);
        wait_done("err");
        n_cmp++;
        if (err !== 1'b1) begin
            n_bad++;
            $display("FAIL err_sticky: got %b, required 1", err);
        end
        start_job();
        n_cmp++;
        if (err !== 1'b0) begin
            n_bad++;
            $display("FAIL err_clear_on_start: got %b, required 0", err);
        end
        for (int s = 0; s < NS; s++)
            for (int k = 0; k < NP; k++) send(s, 2);
        wait_done("err_next");
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_slot   = '0;
        in_psum   = '0;
        out_ready = 1'b1;
        node_addr = NODE;
        mem_addr  = MEM;
        model_clear();
        test_reset();
        test_basic();
        test_order();
        test_backpressure();
        test_back_to_back();
        test_sat();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
